// File: rtl/vid_cnt2axis_if.sv
// vid_cnt2axis_if: AXI4-Stream video bus (tdata/tvalid/tready/tuser/tlast).
// Rev 1.0
`default_nettype none

interface vid_cnt2axis_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/vid_cnt2axis.sv
// vid_cnt2axis: raster counts + pixels to AXI4-Stream video, frame-locked via a FWFT FIFO.
// Rev 1.0
`default_nettype none

module vid_cnt2axis #(
  parameter int H_ACTIVE   = -1,
  parameter int V_ACTIVE   = -1,
  parameter int H_FRAME    = -1,
  parameter int V_FRAME    = -1,
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  localparam int VW = (V_FRAME > 1) ? $clog2(V_FRAME) : 1,
  localparam int HW = (H_FRAME > 1) ? $clog2(H_FRAME) : 1,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LW = AW + 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [VW-1:0]         in_vcnt,
  input  wire logic [HW-1:0]         in_hcnt,
  input  wire logic [DATA_WIDTH-1:0] in_data,
  vid_cnt2axis_if.master             m_axis,
  output logic                       out_overflow,
  input  wire logic                  in_clear_overflow,
  output logic [LW-1:0]              out_level
);

  localparam int            ENTRY_W = DATA_WIDTH + 2;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    RESYNC   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LW-1:0]      level;
  logic [ENTRY_W-1:0] head;
  logic               nonempty, pop, can_write, wr_en, drop;
  logic               active, sof, eol;

  assign active = (int'(in_hcnt) < H_ACTIVE) && (int'(in_vcnt) < V_ACTIVE);
  assign sof    = (in_hcnt == '0) && (in_vcnt == '0);
  assign eol    = active && (int'(in_hcnt) == H_ACTIVE - 1);

  assign nonempty  = (level != '0);
  assign pop       = nonempty && m_axis.tready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign can_write = (level != DEPTH_L) || pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (sof && can_write) begin
          wr_en     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (active) begin
          if (can_write) begin
            wr_en = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = RESYNC;
          end
        end
      end
      RESYNC: begin
        if (sof) begin
          if (can_write) begin
            wr_en     = 1'b1;
            state_nxt = RUN;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {sof, eol, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Setting wins over clearing when both happen in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    out_overflow <= 1'b0;
    else if (drop)              out_overflow <= 1'b1;
    else if (in_clear_overflow) out_overflow <= 1'b0;
  end

  // The RAM is not reset, so the head is masked while the FIFO is empty.
  assign head          = nonempty ? mem[rd_ptr] : '0;
  assign m_axis.tvalid = nonempty;
  assign m_axis.tuser  = head[ENTRY_W-1];
  assign m_axis.tlast  = head[ENTRY_W-2];
  assign m_axis.tdata  = head[DATA_WIDTH-1:0];
  assign out_level     = level;

endmodule

`default_nettype wire

// File: tb/tb_vid_cnt2axis.sv
// tb_vid_cnt2axis: directed raster scenarios for vid_cnt2axis (8x4 active in 12x6 frame, FIFO 4).
// Rev 1.0
`default_nettype none

module tb_vid_cnt2axis;
  localparam int HA = 8;
  localparam int HF = 12;
  localparam int VA = 4;
  localparam int VF = 6;
  localparam int DEP = 4;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [2:0]    vcnt;
  logic [3:0]    hcnt;
  logic [DW-1:0] din;
  logic          ovf;
  logic [2:0]    level;
  logic [25:0]   head;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vid_cnt2axis_if #(.DATA_WIDTH(DW)) ax ();

  vid_cnt2axis #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_FRAME(HF), .V_FRAME(VF),
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vcnt(vcnt), .in_hcnt(hcnt), .in_data(din),
    .m_axis(ax),
    .out_overflow(ovf), .in_clear_overflow(clr), .out_level(level)
  );

  assign head = {ax.tuser, ax.tlast, ax.tdata};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected beat i of a frame: {tuser, tlast, data}
  function automatic logic [25:0] beat(input int i);
    int v, h;
    v = i / HA;
    h = i % HA;
    return {(i == 0), (h == HA - 1), DW'((v << 8) | h)};
  endfunction

  task automatic set_pos(input int v, input int h);
    vcnt = 3'(v);
    hcnt = 4'(h);
    din  = DW'((v << 8) | h);
  endtask

  task automatic step();
    int v, h;
    @(posedge clk);
    #1;
    v = int'(vcnt);
    h = int'(hcnt) + 1;
    if (h == HF) begin
      h = 0;
      v = (v == VF - 1) ? 0 : v + 1;
    end
    set_pos(v, h);
  endtask

  task automatic wait_sof(output int seen);
    seen = 0;
    for (int k = 0; k < 2 * HF * VF && !(vcnt == 3'd0 && hcnt == 4'd0); k++) begin
      step();
      if (ax.tvalid) seen++;
    end
  endtask

  // Steps n cycles with tready=1; each active pixel must appear one cycle later.
  task automatic frame_check(input string tag, input int n, output int beats);
    int pv, ph, maxl;
    maxl = 0;
    beats = 0;
    ax.tready = 1'b1;
    for (int k = 0; k < n; k++) begin
      pv = int'(vcnt);
      ph = int'(hcnt);
      step();
      if (ph < HA && pv < VA) begin
        chk({tag, " beat"}, 32'({ax.tvalid, head}), 32'({1'b1, beat(pv * HA + ph)}));
        beats++;
      end else begin
        chk({tag, " idle"}, 32'(ax.tvalid), 32'(0));
      end
      if (int'(level) > maxl) maxl = int'(level);
    end
    chk({tag, " level<=1"}, 32'(maxl <= 1), 32'(1));
    chk({tag, " ovf"}, 32'(ovf), 32'(0));
  endtask

  initial begin
    int seen, beats, idx;
    bit stall;
    logic [25:0] saved;

    rst = 1'b1;
    clr = 1'b0;
    ax.tready = 1'b1;
    set_pos(2, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst tvalid", 32'(ax.tvalid), 32'(0));
    chk("rst head", 32'(head), 32'(0));
    chk("rst ovf", 32'(ovf), 32'(0));
    chk("rst level", 32'(level), 32'(0));
    rst = 1'b0;

    // Start mid-frame: nothing until the raster wraps to (0,0)
    wait_sof(seen);
    chk("t1 pre-sof", 32'(seen), 32'(0));
    frame_check("t1", HF * VF, beats);
    chk("t1 beats", 32'(beats), 32'(32));
    frame_check("t2", HF * VF, beats);
    chk("t2 beats", 32'(beats), 32'(32));

    // Stall from SOF: four queued, (0,4) dropped while clear is pulsed
    ax.tready = 1'b0;
    repeat (4) step();
    chk("t3 level full", 32'(level), 32'(DEP));
    chk("t3 head sof", 32'({ax.tvalid, head}), 32'({1'b1, beat(0)}));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3 ovf set over clear", 32'(ovf), 32'(1));
    chk("t3 level after drop", 32'(level), 32'(DEP));
    ax.tready = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      chk("t3 drain", 32'({ax.tvalid, head}), 32'({1'b1, beat(k)}));
      step();
    end
    chk("t3 empty", 32'({ax.tvalid, level}), 32'(0));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6 ovf cleared", 32'(ovf), 32'(0));
    wait_sof(seen);
    chk("t3 resync quiet", 32'(seen), 32'(0));
    frame_check("t3 resync", HF * VF, beats);
    chk("t3 resync beats", 32'(beats), 32'(32));

    // tready toggles through line 0, then stays high; order and stall stability
    idx = 0;
    for (int cyc = 0; cyc < HF * VF; cyc++) begin
      ax.tready = (cyc < HF) ? cyc[0] : 1'b1;
      if (ax.tvalid && ax.tready) begin
        chk("t4 order", 32'(head), 32'(beat(idx)));
        idx++;
      end
      stall = ax.tvalid && !ax.tready;
      saved = head;
      step();
      if (stall) chk("t4 hold", 32'({ax.tvalid, head}), 32'({1'b1, saved}));
    end
    chk("t4 beats", 32'(idx), 32'(32));
    chk("t4 ovf", 32'(ovf), 32'(0));
    chk("t4 level", 32'(level), 32'(0));

    // Reset at (2,3) with three beats queued
    ax.tready = 1'b1;
    for (int k = 0; k < 2 * HF; k++) step();
    ax.tready = 1'b0;
    repeat (3) step();
    chk("t5 level 3", 32'(level), 32'(3));
    chk("t5 pos", 32'({vcnt, hcnt}), 32'({3'd2, 4'd3}));
    rst = 1'b1;
    #1;
    chk("t5 async out", 32'({ax.tvalid, head}), 32'(0));
    chk("t5 async level", 32'(level), 32'(0));
    repeat (2) step();
    rst = 1'b0;
    ax.tready = 1'b1;
    wait_sof(seen);
    chk("t5 quiet", 32'(seen), 32'(0));
    frame_check("t5", HF * VF, beats);
    chk("t5 beats", 32'(beats), 32'(32));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

`default_nettype wire
